shared_data_mem: RTL
====================

Name: shared_data_mem

Overview:
- Single-port synchronous data memory shared by NUM_CORES processor cores through a round-robin arbiter.
- Serves one read or write per clock and returns read data with registered, one-hot acknowledge.
- Generalises the per-core data memory to multi-core access with grant/ack handshake and reset-defined outputs.
- Sits between the core array and the shared data RAM.

Parameters:
- data_width, 12, width of each memory word.
- address_width, 12, word address width; depth = 2**address_width (4096 words by default).
- NUM_CORES, 4, number of requesting cores; must be at least 2.

Ports:
- clock  input  1  rising-edge clock.
- rstN  input  1  asynchronous, active-low reset.
- req  input  NUM_CORES  per-core access request, bit i = core i.
- wren  input  NUM_CORES  per-core write enable; 1 = write, 0 = read; qualified by req.
- address  input  NUM_CORES*address_width  packed addresses; core i uses bits [i*address_width +: address_width].
- data  input  NUM_CORES*data_width  packed write data; core i uses slice [i*data_width +: data_width].
- gnt  output  NUM_CORES  combinational one-hot grant for the current cycle.
- ack  output  NUM_CORES  registered one-hot completion pulse, one cycle after grant.
- q  output  data_width  registered read data, shared by all cores; valid when ack[i] follows a read by core i.

Behaviour:
- Reset (rstN=0, async): ack=0, q=0, priority pointer ptr=0; gnt forced to 0 while rstN=0. Memory contents are not reset.
- Arbitration, combinational:
  - Winner is the first index with req=1 scanning ptr, ptr+1, ... NUM_CORES-1, 0, ... wrapping.
  - gnt is one-hot on the winner, or all-zero when req=0.
- Access at the rising edge ending a cycle with gnt[w]=1:
  - If wren[w]=1: memory[address_w] <= data_w; q holds its previous value.
  - If wren[w]=0: q <= memory[address_w].
  - ack <= one-hot(w); ptr <= (w+1) mod NUM_CORES.
- Idle edge (no req): ack <= 0; q and ptr hold.
- Latency: grant in cycle T, access at edge T/T+1, ack and read q visible throughout cycle T+1. Back-to-back accesses give one per cycle; ack is a single-cycle pulse per access.
- Handshake:
  - A core holds req, wren, address and data stable until it sees its gnt bit high at a rising edge.
  - req still high in the following cycle is a new request.
  - gnt depends combinationally on inputs; cores sample gnt only at the clock edge.
- Fairness: a continuously requesting core waits at most NUM_CORES-1 grants. When all cores request every cycle, grant order is 0,1,...,NUM_CORES-1,0,...
- Read-during-write: impossible, since only one access happens per cycle. A read in cycle T+1 of an address written at edge T returns the new data.
- Address range: full 0 .. 2**address_width-1, no wrap or aliasing. Address 4095 is valid at defaults.
- Reset mid-operation: a pending access is abandoned, nothing is written, ack clears immediately, ptr returns to 0. After release, the first grant follows priority from core 0.
- ptr register width is $clog2(NUM_CORES); wrap uses mod NUM_CORES (non-power-of-2 counts supported).

Test Plan:
1. Reset: assert rstN=0 with req=4'b1111 -> gnt=0, ack=0, q=0. Release -> gnt=4'b0001 in the same cycle.
2. Single core: core 2 writes 12'hABC to addr 12'd4095, then reads addr 4095 -> ack=4'b0100 one cycle after each grant; q=12'hABC during the read ack; q unchanged during the write ack.
3. Contention: all four cores request reads of addrs 10,11,12,13 (preloaded 1,2,3,4) continuously -> gnt sequence 0001,0010,0100,1000,0001; q sequence 1,2,3,4 aligned with ack.
4. Pointer wrap: after core 3 is granted, cores 0 and 3 request together -> core 0 is granted first, core 3 next.
5. Idle hold: a read returns q=12'h05A, then 3 idle cycles -> ack=0 and q stays 12'h05A.
6. Reset mid-access: core 1 is granted a write of 12'h777 to addr 20 (previously 12'h111), and rstN drops before the edge -> after release, a read of addr 20 returns 12'h111.

Source files
------------

// File: rtl/shared_data_mem.sv
// Single-port data RAM shared by NUM_CORES cores through a round-robin arbiter.
// One access per clock; registered one-hot ack and shared registered read data.
module shared_data_mem #(
    parameter int unsigned data_width    = 12,
    parameter int unsigned address_width = 12,
    parameter int unsigned NUM_CORES     = 4
) (
    input  logic                               clock,
    input  logic                               rstN,
    input  logic [NUM_CORES-1:0]               req,
    input  logic [NUM_CORES-1:0]               wren,
    input  logic [NUM_CORES*address_width-1:0] address,
    input  logic [NUM_CORES*data_width-1:0]    data,
    output logic [NUM_CORES-1:0]               gnt,
    output logic [NUM_CORES-1:0]               ack,
    output logic [data_width-1:0]              q
);

    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned DEPTH = 1 << address_width;

    logic [PTR_W-1:0]         ptr;
    logic [PTR_W-1:0]         ptr_nxt;
    logic [PTR_W-1:0]         win;
    logic                     win_vld;
    logic [PTR_W-1:0]         cand     [NUM_CORES];
    logic [address_width-1:0] addr_arr [NUM_CORES];
    logic [data_width-1:0]    data_arr [NUM_CORES];
    logic                     sel_wren;
    logic [address_width-1:0] sel_addr;
    logic [data_width-1:0]    sel_data;
    logic [data_width-1:0]    mem      [DEPTH];

    // Unpack per-core buses and build the priority scan order starting at ptr
    for (genvar g = 0; g < int'(NUM_CORES); g++) begin : g_unpack
        assign addr_arr[g] = address[g*address_width +: address_width];
        assign data_arr[g] = data[g*data_width +: data_width];
        assign cand[g]     = PTR_W'((int'(ptr) + g) % int'(NUM_CORES));
    end

    // Round-robin winner: first requester found scanning from ptr with wrap
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (!win_vld && req[cand[i]]) begin
                win     = cand[i];
                win_vld = 1'b1;
            end
        end
    end

    // Grant decode (held off during reset) and winner's access fields
    always_comb begin
        gnt = '0;
        if (rstN && win_vld) begin
            gnt[win] = 1'b1;
        end
        sel_wren = wren[win];
        sel_addr = addr_arr[win];
        sel_data = data_arr[win];
        ptr_nxt  = PTR_W'((int'(win) + 1) % int'(NUM_CORES));
    end

    // RAM write port; contents are not reset, gnt is already gated by rstN
    always_ff @(posedge clock) begin
        if (rstN && win_vld && sel_wren) begin
            mem[sel_addr] <= sel_data;
        end
    end

    // Ack pulse, read data and priority pointer
    always_ff @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            ack <= '0;
            q   <= '0;
            ptr <= '0;
        end else begin
            ack <= gnt;
            if (win_vld) begin
                ptr <= ptr_nxt;
                if (!sel_wren) begin
                    q <= mem[sel_addr];
                end
            end
        end
    end

endmodule
